icache_sa: RTL and testbench
============================

Name: icache_sa

Overview:
- Parametrised successor instruction cache: configurable geometry, 1- or 2-way set-associative, LRU replacement.
- Fetch side and memory side both use explicit valid/ready handshakes, replacing the fixed-penalty loop.
- Adds a flush (invalidate-all) operation and hit/miss performance counters.
- Sits between the fetch stage and the line-granular instruction memory port.

Parameters:
- ADDR_W, 32, fetch address width.
- LINE_BYTES, 32, bytes per line; power of 2, at least 4.
- NUM_SETS, 1024, sets per way; power of 2, at least 2.
- WAYS, 2, associativity; legal values 1 or 2.
- Derived: OFF_W=log2(LINE_BYTES), IDX_W=log2(NUM_SETS), TAG_W=ADDR_W-IDX_W-OFF_W, LINE_BITS=8*LINE_BYTES.

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset, asynchronous, active-low.
- req_valid  in  1  fetch request.
- req_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored.
- req_ready  out  1  cache can accept a request.
- resp_valid  out  1  one-cycle pulse, instruction valid.
- resp_data  out  32  fetched instruction.
- mem_req_valid  out  1  line fill request.
- mem_req_addr  out  ADDR_W  line-aligned fill address (offset bits zero).
- mem_req_ready  in  1  memory accepts the request.
- mem_resp_valid  in  1  fill data valid.
- mem_resp_data  in  LINE_BITS  fill line; byte 0 in the MSBs.
- flush  in  1  invalidate all lines (level sampled).
- flush_busy  out  1  flush in progress or pending.
- hit_count  out  32  hits since reset; wraps at 2^32.
- miss_count  out  32  misses since reset; wraps at 2^32.

Behaviour:
- Reset (async, low): state IDLE; all valid bits 0; all LRU bits 0; req_ready=0 while RESET is low, 1 in the first cycle after; resp_valid=0; resp_data=0; mem_req_valid=0; mem_req_addr=0; flush_busy=0; both counters 0.
- Data and tag arrays are not reset.
- Address split: tag=addr[ADDR_W-1 -: TAG_W], index=addr[OFF_W +: IDX_W], word offset=addr[OFF_W-1:2].
- Word select: word w is line[LINE_BITS-1-32*w -: 32].
- FSM states: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, RESP, FLUSH.
- req_ready = (state==IDLE) && !flush && !flush_pending.
- IDLE: on req_valid&&req_ready, latch the address and go to LOOKUP.
  - Else, if flush or flush_pending: set index counter to 0 and go to FLUSH.
- LOOKUP: compare tag against every valid way.
  - Hit: register the word into resp_data, set resp_valid=1 for the next cycle, hit_count+1, LRU[set] points to the other way (WAYS=2), go to RESP.
  - Miss: miss_count+1, go to MISS_REQ.
- MISS_REQ: mem_req_valid=1, mem_req_addr={tag,index,0}; both held stable until mem_req_ready, then go to MISS_WAIT.
- MISS_WAIT: on mem_resp_valid, write the line and tag into the victim way, set its valid bit, update LRU, register the word from mem_resp_data into resp_data, resp_valid=1, go to RESP.
- Victim selection: invalid way 0 first, then invalid way 1, else the way LRU[set] points to. WAYS=1: always way 0.
- RESP: resp_valid high for this cycle only, then go to IDLE. resp_data holds its value until the next response.
- Hit latency: accept at edge E0, resp_valid high in the cycle after E2.
- Miss latency: accept at E0, mem_req_valid high after E1, resp_valid high the cycle after the mem_resp_valid edge.
- FLUSH: clear valid and LRU for one set per cycle across all ways; NUM_SETS cycles total; then go to IDLE.
  - flush_busy is high in FLUSH or while flush_pending is set.
- Flush asserted outside IDLE: set flush_pending. The in-flight miss completes and returns its response, then FLUSH runs.
- Flush and req_valid in the same IDLE cycle: flush wins; the request is not accepted.
- mem_resp_valid outside MISS_WAIT: ignored, no array write.
- Reset during a miss: abort to IDLE, drop mem_req_valid. The memory side must discard the outstanding fill.
- Counters increment once per lookup, never during MISS_WAIT retries.

Decomposition:
- Package icache_pkg: state enum, clog2 helper, derived-width localparam functions, word-select function.
- Sub-module icache_way_array, one instance per way:
  - tag and data storage with combinational read by index;
  - a single write port;
  - valid-bit flops with async clear;
  - a per-index clear for flush.
- LRU bits and FSM stay in the top level.

Test Plan:
- Reset, then fetch 0x0000_1004 with memory supplying a line of bytes 0x00..0x1F -> one mem_req at 0x0000_1000; resp_data=0x04050607; miss_count=1.
- Repeat fetch 0x0000_1008 -> no mem_req; resp_valid exactly 2 edges after accept; resp_data=0x08090A0B; hit_count=1.
- WAYS=2: fill 0x0000_1000, 0x0010_1000 (same set), touch 0x0000_1000, fetch 0x0020_1000 -> way holding 0x0010_1000 evicted. Refetch 0x0000_1000 hits; refetch 0x0010_1000 misses.
- Hold mem_req_ready=0 for 5 cycles, then give mem_resp_valid 3 cycles after acceptance -> mem_req_addr stable throughout; single resp_valid pulse; stray mem_resp_valid while IDLE has no effect.
- Pulse flush during MISS_WAIT -> miss response delivered first; flush_busy high for NUM_SETS+ cycles; req_ready low meanwhile; next fetch of the previous hit address misses.
- Assert RESET mid-MISS_REQ -> mem_req_valid=0 immediately; counters 0; the next fetch misses.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared state encoding and geometry helpers for the set-associative instruction cache.
package icache_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StMissReq,
    StMissWait,
    StResp,
    StFlush
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(n)) r++;
    end
    return r;
  endfunction

  function automatic int unsigned off_width(input int unsigned line_bytes);
    return clog2(line_bytes);
  endfunction

  function automatic int unsigned idx_width(input int unsigned num_sets);
    return clog2(num_sets);
  endfunction

  function automatic int unsigned tag_width(input int unsigned addr_w,
                                            input int unsigned line_bytes,
                                            input int unsigned num_sets);
    return addr_w - off_width(line_bytes) - idx_width(num_sets);
  endfunction

  // Byte 0 of a line sits in the MSBs, so word w starts LINE_BITS-32*(w+1) bits up.
  function automatic int unsigned word_lsb(input int unsigned line_bits, input int unsigned w);
    return line_bits - 32 * (w + 1);
  endfunction

endpackage

// File: rtl/icache_way_array.sv
// One cache way: tag/data storage with combinational read, one write port, resettable valids.
module icache_way_array
  import icache_pkg::*;
#(
  parameter int unsigned TAG_W     = 17,
  parameter int unsigned IDX_W     = 10,
  parameter int unsigned LINE_BITS = 256
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic                 rd_valid,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [LINE_BITS-1:0] rd_data,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic [LINE_BITS-1:0] wr_data,
  input  logic                 clr_en,
  input  logic [IDX_W-1:0]     clr_idx
);

  localparam int unsigned SETS = 1 << IDX_W;

  logic [TAG_W-1:0]     tag_mem  [SETS];
  logic [LINE_BITS-1:0] data_mem [SETS];
  logic [SETS-1:0]      valid_q;

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_q <= '0;
    end else if (clr_en) begin
      valid_q[clr_idx] <= 1'b0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache (1 or 2 ways, LRU) with handshaked fetch and fill ports,
// invalidate-all flush and hit/miss counters.
module icache_sa
  import icache_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_BYTES = 32,
  parameter int unsigned NUM_SETS   = 1024,
  parameter int unsigned WAYS       = 2
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      req_valid,
  input  logic [ADDR_W-1:0]         req_addr,
  output logic                      req_ready,
  output logic                      resp_valid,
  output logic [31:0]               resp_data,
  output logic                      mem_req_valid,
  output logic [ADDR_W-1:0]         mem_req_addr,
  input  logic                      mem_req_ready,
  input  logic                      mem_resp_valid,
  input  logic [8*LINE_BYTES-1:0]   mem_resp_data,
  input  logic                      flush,
  output logic                      flush_busy,
  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count
);

  localparam int unsigned OFF_W     = off_width(LINE_BYTES);
  localparam int unsigned IDX_W     = idx_width(NUM_SETS);
  localparam int unsigned TAG_W     = tag_width(ADDR_W, LINE_BYTES, NUM_SETS);
  localparam int unsigned LINE_BITS = 8 * LINE_BYTES;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_data_q, resp_data_d;
  logic                  pend_q, pend_d;
  logic [IDX_W-1:0]      fidx_q, fidx_d;
  logic [31:0]           hit_q, hit_d;
  logic [31:0]           miss_q, miss_d;
  logic [NUM_SETS-1:0]   lru_q;

  logic [TAG_W-1:0]      tag;
  logic [IDX_W-1:0]      idx;
  logic [31:0]           woff;
  logic [1:0]            way_valid;
  logic [1:0][TAG_W-1:0] way_tag;
  logic [1:0][LINE_BITS-1:0] way_data;
  logic                  hit;
  logic                  hit_way;
  logic [LINE_BITS-1:0]  hit_line;
  logic                  victim;
  logic                  fill_en;
  logic                  clr_en;
  logic                  lru_we;
  logic                  lru_val;
  logic [IDX_W-1:0]      lru_idx;

  assign tag  = addr_q[ADDR_W-1 -: TAG_W];
  assign idx  = addr_q[OFF_W +: IDX_W];
  assign woff = 32'(addr_q[OFF_W-1:0]) >> 2;

  for (genvar g = 0; g < 2; g++) begin : g_way
    if (g < WAYS) begin : g_inst
      icache_way_array #(
        .TAG_W    (TAG_W),
        .IDX_W    (IDX_W),
        .LINE_BITS(LINE_BITS)
      ) u_way (
        .CLK     (CLK),
        .RESET   (RESET),
        .rd_idx  (idx),
        .rd_valid(way_valid[g]),
        .rd_tag  (way_tag[g]),
        .rd_data (way_data[g]),
        .wr_en   (fill_en && (victim == 1'(g))),
        .wr_idx  (idx),
        .wr_tag  (tag),
        .wr_data (mem_resp_data),
        .clr_en  (clr_en),
        .clr_idx (fidx_q)
      );
    end else begin : g_tie
      // Absent way looks permanently valid so it never wins victim selection.
      assign way_valid[g] = 1'b1;
      assign way_tag[g]   = '0;
      assign way_data[g]  = '0;
    end
  end

  always_comb begin
    hit      = 1'b0;
    hit_way  = 1'b0;
    hit_line = way_data[0];
    for (int w = 0; w < int'(WAYS); w++) begin
      if (way_valid[w] && (way_tag[w] == tag)) begin
        hit      = 1'b1;
        hit_way  = 1'(w);
        hit_line = way_data[w];
      end
    end
  end

  always_comb begin
    if (WAYS == 1 || !way_valid[0]) begin
      victim = 1'b0;
    end else if (!way_valid[1]) begin
      victim = 1'b1;
    end else begin
      victim = lru_q[idx];
    end
  end

  assign req_ready     = RESET && (state_q == StIdle) && !flush && !pend_q;
  assign mem_req_valid = (state_q == StMissReq);
  assign mem_req_addr  = {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)};
  assign flush_busy    = (state_q == StFlush) || pend_q;
  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;
  assign hit_count     = hit_q;
  assign miss_count    = miss_q;
  assign lru_idx       = (state_q == StFlush) ? fidx_q : idx;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    pend_d       = pend_q;
    fidx_d       = fidx_q;
    hit_d        = hit_q;
    miss_d       = miss_q;
    fill_en      = 1'b0;
    clr_en       = 1'b0;
    lru_we       = 1'b0;
    lru_val      = 1'b0;

    if (flush && (state_q != StIdle) && (state_q != StFlush)) pend_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          addr_d  = req_addr;
          state_d = StLookup;
        end else if (flush || pend_q) begin
          fidx_d  = '0;
          pend_d  = 1'b0;
          state_d = StFlush;
        end
      end
      StLookup: begin
        if (hit) begin
          resp_data_d = hit_line[word_lsb(LINE_BITS, woff) +: 32];
          hit_d       = hit_q + 32'd1;
          lru_we      = 1'b1;
          lru_val     = ~hit_way;
          state_d     = StResp;
        end else begin
          miss_d  = miss_q + 32'd1;
          state_d = StMissReq;
        end
      end
      StMissReq: begin
        if (mem_req_ready) state_d = StMissWait;
      end
      StMissWait: begin
        if (mem_resp_valid) begin
          fill_en      = 1'b1;
          lru_we       = 1'b1;
          lru_val      = ~victim;
          resp_data_d  = mem_resp_data[word_lsb(LINE_BITS, woff) +: 32];
          resp_valid_d = 1'b1;
          state_d      = StResp;
        end
      end
      StResp: begin
        // A fill already raised the pulse; a hit raises it here, one cycle later.
        resp_valid_d = !resp_valid_q;
        state_d      = StIdle;
      end
      StFlush: begin
        clr_en = 1'b1;
        lru_we = 1'b1;
        if (fidx_q == IDX_W'(NUM_SETS - 1)) begin
          state_d = StIdle;
        end else begin
          fidx_d = fidx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      pend_q       <= 1'b0;
      fidx_q       <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      pend_q       <= pend_d;
      fidx_q       <= fidx_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      lru_q <= '0;
    end else if (lru_we) begin
      lru_q[lru_idx] <= lru_val;
    end
  end

endmodule

// File: tb/tb_icache_sa.sv
// Scoreboard bench for icache_sa: expected words queued at issue, compared on resp_valid.
module tb_icache_sa;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned LINE_BYTES = 32;
  localparam int unsigned NUM_SETS   = 1024;
  localparam int unsigned WAYS       = 2;
  localparam int unsigned LINE_BITS  = 8 * LINE_BYTES;

  logic                 CLK;
  logic                 RESET;
  logic                 req_valid;
  logic [ADDR_W-1:0]    req_addr;
  logic                 req_ready;
  logic                 resp_valid;
  logic [31:0]          resp_data;
  logic                 mem_req_valid;
  logic [ADDR_W-1:0]    mem_req_addr;
  logic                 mem_req_ready;
  logic                 mem_resp_valid;
  logic [LINE_BITS-1:0] mem_resp_data;
  logic                 flush;
  logic                 flush_busy;
  logic [31:0]          hit_count;
  logic [31:0]          miss_count;

  int          checks = 0;
  int          errors = 0;
  int          hits_exp = 0;
  int          misses_exp = 0;
  logic [31:0] exp_q[$];

  icache_sa #(
    .ADDR_W    (ADDR_W),
    .LINE_BYTES(LINE_BYTES),
    .NUM_SETS  (NUM_SETS),
    .WAYS      (WAYS)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .flush         (flush),
    .flush_busy    (flush_busy),
    .hit_count     (hit_count),
    .miss_count    (miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Memory image: byte i of the line at la is la[23:16] + i.
  function automatic logic [LINE_BITS-1:0] make_line(input logic [31:0] la);
    logic [LINE_BITS-1:0] l;
    for (int i = 0; i < int'(LINE_BYTES); i++) l[LINE_BITS-1-8*i -: 8] = la[23:16] + 8'(i);
    return l;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [7:0] b0;
    b0 = a[23:16] + {3'b000, a[4:2], 2'b00};
    return {b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3};
  endfunction

  always @(negedge CLK) begin
    if (RESET && resp_valid) begin
      check_eq("resp_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check_eq("resp_data", 64'(resp_data), 64'(exp_q.pop_front()));
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    check_eq("req_ready", 64'(req_ready), 64'd1);
  endtask

  task automatic fetch(input logic [31:0] a, input bit miss, input int rdy_hold,
                       input int resp_lat, input bit do_flush);
    logic [31:0] la;
    la = a & ~32'h1F;
    wait_ready();
    exp_q.push_back(exp_word(a));
    req_valid = 1'b1;
    req_addr  = a;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(posedge CLK); #1;
    check_eq("miss_path", 64'(mem_req_valid), 64'(miss));
    if (miss) begin
      misses_exp++;
      check_eq("mem_addr", 64'(mem_req_addr), 64'(la));
      for (int i = 0; i < rdy_hold; i++) begin
        @(posedge CLK); #1;
        check_eq("mem_hold", {31'b0, mem_req_valid, mem_req_addr}, {32'd1, la});
      end
      mem_req_ready = 1'b1;
      @(posedge CLK); #1;
      mem_req_ready = 1'b0;
      if (do_flush) begin
        flush = 1'b1;
        @(posedge CLK); #1;
        flush = 1'b0;
        check_eq("flush_pend", 64'(flush_busy), 64'd1);
      end
      for (int i = 0; i < resp_lat; i++) begin
        @(posedge CLK); #1;
      end
      mem_resp_valid = 1'b1;
      mem_resp_data  = make_line(la);
      @(posedge CLK); #1;
      mem_resp_valid = 1'b0;
      check_eq("miss_lat", 64'(resp_valid), 64'd1);
    end else begin
      hits_exp++;
      check_eq("hit_early", 64'(resp_valid), 64'd0);
      @(posedge CLK); #1;
      check_eq("hit_lat", 64'(resp_valid), 64'd1);
    end
    @(posedge CLK); #1;
    check_eq("resp_pulse", 64'(resp_valid), 64'd0);
    check_eq("hit_count", 64'(hit_count), 64'(hits_exp));
    check_eq("miss_count", 64'(miss_count), 64'(misses_exp));
  endtask

  initial begin
    int n;
    int bad;
    RESET          = 1'b0;
    req_valid      = 1'b0;
    req_addr       = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    flush          = 1'b0;
    #2;
    check_eq("rst_req_ready", 64'(req_ready), 64'd0);
    check_eq("rst_resp", {31'b0, resp_valid, resp_data}, 64'd0);
    check_eq("rst_mem", {31'b0, mem_req_valid, mem_req_addr}, 64'd0);
    check_eq("rst_flush_busy", 64'(flush_busy), 64'd0);
    check_eq("rst_counts", {hit_count, miss_count}, 64'd0);
    @(posedge CLK); @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    check_eq("ready_after_rst", 64'(req_ready), 64'd1);

    fetch(32'h0000_1004, 1'b1, 0, 0, 1'b0);
    fetch(32'h0000_1008, 1'b0, 0, 0, 1'b0);

    // Same set, different tags: LRU must evict the line not touched most recently.
    fetch(32'h0010_1000, 1'b1, 0, 1, 1'b0);
    fetch(32'h0000_1000, 1'b0, 0, 0, 1'b0);
    fetch(32'h0020_101C, 1'b1, 0, 0, 1'b0);
    fetch(32'h0000_1010, 1'b0, 0, 0, 1'b0);
    fetch(32'h0020_1004, 1'b0, 0, 0, 1'b0);
    fetch(32'h0010_1000, 1'b1, 0, 0, 1'b0);

    fetch(32'h0000_2004, 1'b1, 5, 2, 1'b0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = '1;
    @(posedge CLK); @(posedge CLK); #1;
    mem_resp_valid = 1'b0;
    check_eq("stray_resp", 64'(resp_valid), 64'd0);
    fetch(32'h0000_2004, 1'b0, 0, 0, 1'b0);

    fetch(32'h0000_4000, 1'b1, 0, 1, 1'b1);
    n   = 0;
    bad = 0;
    while (flush_busy && n < 3000) begin
      if (req_ready) bad++;
      @(posedge CLK); #1;
      n++;
    end
    check_eq("flush_len_min", 64'(n >= int'(NUM_SETS)), 64'd1);
    check_eq("flush_done", 64'(flush_busy), 64'd0);
    check_eq("flush_ready_low", 64'(bad), 64'd0);
    fetch(32'h0000_1008, 1'b1, 0, 0, 1'b0);

    // Reset while the fill request is outstanding.
    wait_ready();
    req_valid = 1'b1;
    req_addr  = 32'h0000_5000;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(posedge CLK); #1;
    check_eq("abort_req", 64'(mem_req_valid), 64'd1);
    #2;
    RESET = 1'b0;
    #1;
    check_eq("abort_drop", 64'(mem_req_valid), 64'd0);
    check_eq("abort_counts", {hit_count, miss_count}, 64'd0);
    check_eq("abort_ready", 64'(req_ready), 64'd0);
    hits_exp   = 0;
    misses_exp = 0;
    @(posedge CLK); @(posedge CLK); #1;
    RESET = 1'b1;
    fetch(32'h0000_1000, 1'b1, 0, 0, 1'b0);

    check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
